// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module   : regfile_pkg
//  Brief    : Shared types and default sizes for the multi-port register file
//             and its dump streamer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    // Default geometry of the register file
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;

    // Dump streamer states
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_dump_fsm.sv
// ============================================================================
//  Module   : regfile_dump_fsm
//  Brief    : Sequencer that walks every register index once per dump request
//             with a valid/ready handshake. It tells the parent which index
//             to capture on the coming edge (cap_en / cap_idx) so that the
//             data register always samples the pre-edge array content.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump_start,
    input  logic          dump_ready,
    output logic          dump_busy,
    output logic          dump_valid,
    output logic [AW-1:0] dump_idx,
    output logic          cap_en,
    output logic [AW-1:0] cap_idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q,   idx_d;

    // State and index registers; reset aborts any dump in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state, index advance and capture request
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap_en  = 1'b0;
        cap_idx = '0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    cap_en  = 1'b1;
                    cap_idx = '0;
                end
            end
            STREAM: begin
                // dump_start is deliberately ignored here
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cap_en  = 1'b1;
                        cap_idx = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign dump_valid = (state_q == STREAM);
    assign dump_busy  = (state_q == STREAM);
    assign dump_idx   = idx_q;

endmodule : regfile_dump_fsm

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
//  Module   : regfile_mp
//  Brief    : Parameterised register file with NRD combinational read ports,
//             one synchronous write port and a streaming dump interface that
//             emits every register once, one beat per accepted handshake.
//             Optional build macro REGFILE_BYPASS_EN forwards same-cycle
//             write data to matching read ports.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                we,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                dump_start,
    output logic                dump_busy,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [AW-1:0]       dump_idx,
    output logic [XLEN-1:0]     dump_data
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    // True for an address that maps to a real, writable register; address 0
    // is excluded when it is hardwired to zero.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] dump_data_q, dump_data_d;
    logic            wr_ok;
    logic            cap_en;
    logic [AW-1:0]   cap_idx;

    assign wr_ok = we && addr_live(wr_addr);

    // Array next value: a single write lands when the address is live
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Register array storage with asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports; dead addresses read as zero
    always_comb begin
        logic [AW-1:0] rd_a;
        rd_a    = '0;
        rd_data = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_a = rd_addr[p*AW +: AW];
            if (addr_live(rd_a)) begin
                rd_data[p*XLEN +: XLEN] = regs_q[rd_a];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (rd_a == wr_addr)) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
            end
`endif
        end
    end

    // Dump data capture reads the pre-edge array, never the bypass path
    always_comb begin
        dump_data_d = dump_data_q;
        if (cap_en) begin
            dump_data_d = addr_live(cap_idx) ? regs_q[cap_idx] : '0;
        end
    end

    // Dump data register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dump_data_q <= '0;
        end else begin
            dump_data_q <= dump_data_d;
        end
    end

    assign dump_data = dump_data_q;

    regfile_dump_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_dump_fsm (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .dump_ready (dump_ready),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_idx   (dump_idx),
        .cap_en     (cap_en),
        .cap_idx    (cap_idx)
    );

endmodule : regfile_mp

`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of registers; legal range 2..256.
REQ-003 SHALL have parameter NRD, default 2: number of read ports; legal range 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-005 SHALL use derived constant AW = clog2(NREGS).
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port rd_addr  in  NRD*AW  packed read addresses; port p uses bits [p*AW +: AW].
REQ-009 SHALL have port rd_data  out  NRD*XLEN  packed read data; port p uses bits [p*XLEN +: XLEN].
REQ-010 SHALL have port we  in  1  write enable.
REQ-011 SHALL have port wr_addr  in  AW  write address.
REQ-012 SHALL have port wr_data  in  XLEN  write data.
REQ-013 SHALL have port dump_start  in  1  single-cycle request to stream out all registers.
REQ-014 SHALL have port dump_busy  out  1  high while a dump is in progress.
REQ-015 SHALL have port dump_valid  out  1  dump beat valid.
REQ-016 SHALL have port dump_ready  in  1  consumer accepts the beat.
REQ-017 SHALL have port dump_idx  out  AW  index of the current beat.
REQ-018 SHALL have port dump_data  out  XLEN  value of the current beat.

Function
REQ-019 Reads SHALL be combinational: rd_data[p] = array[rd_addr[p]] in the same cycle.
REQ-020 Writes SHALL commit on the rising clk edge when we=1; the value is visible to a plain read in the next cycle.
REQ-021 Any rd_addr >= NREGS SHALL return 0; a write with wr_addr >= NREGS SHALL be ignored.
REQ-022 With ZERO_REG=1, writes to address 0 SHALL be ignored and reads of address 0 SHALL return 0; this also applies to the dump beat for index 0.
REQ-023 The dump FSM SHALL have two states: IDLE and STREAM.
REQ-024 IDLE->STREAM SHALL occur on dump_start=1; on that edge dump_idx=0 and dump_data=array[0].
REQ-025 In STREAM, dump_valid=1 and dump_busy=1; in IDLE, both are 0.
REQ-026 On dump_valid&dump_ready with dump_idx<NREGS-1, dump_idx SHALL increment and dump_data SHALL load array[dump_idx+1].
REQ-027 On dump_valid&dump_ready with dump_idx=NREGS-1, the FSM SHALL return to IDLE and dump_idx SHALL reset to 0.
REQ-028 dump_idx and dump_data SHALL hold stable while dump_valid=1 and dump_ready=0.
REQ-029 A dump capture SHALL sample the pre-edge array content; a same-cycle write to the captured index is not included.
REQ-030 dump_start SHALL be ignored while in STREAM; register writes SHALL proceed normally during a dump.
REQ-031 Throughput SHALL be one beat per cycle when dump_ready is held high: NREGS beats in NREGS cycles.

Reset
REQ-032 With rst=0, all registers, dump_idx and dump_data SHALL asynchronously clear to 0; the FSM SHALL go to IDLE; dump_valid and dump_busy SHALL be 0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no further beats; a new dump_start is required after reset is released.

Configuration
REQ-034 Macro REGFILE_BYPASS_EN: when defined, a read of an address being written in the same cycle (we=1, valid non-zero-reg address) SHALL return wr_data combinationally; when undefined, it SHALL return the old array value.

Structure
REQ-035 Package regfile_pkg SHALL hold the dump state enum (IDLE, STREAM) and the default values of XLEN, NREGS and NRD.
REQ-036 The dump FSM SHALL be the sub-module regfile_dump_fsm. It SHALL own the state, the index counter and the handshake, and it SHALL output the capture index.

Verification
REQ-037 Reset, then write 0xDEADBEEF to x5; in the next cycle rd_addr[0]=5 SHALL read 0xDEADBEEF and rd_addr[1]=6 SHALL read 0.
REQ-038 With ZERO_REG=1, write 0x12345678 to x0; reading x0 SHALL return 0 on every port.
REQ-039 Write 0xA5A5A5A5 to x7 and read x7 in the same cycle: SHALL return 0xA5A5A5A5 with REGFILE_BYPASS_EN defined and 0 without it.
REQ-040 Load xi=i for all i, pulse dump_start, hold dump_ready=1: SHALL produce 32 consecutive beats with idx/data 0..31, then dump_busy=0 in the cycle after the final beat.
REQ-041 During a dump, drop dump_ready for 3 cycles at idx=10: idx=10 and data=10 SHALL hold; a dump_start pulse in that window SHALL be ignored.
REQ-042 Assert rst=0 at idx=15 mid-dump: dump_valid SHALL be 0 immediately, all registers SHALL read 0, and the FSM SHALL remain IDLE after release.
